reg_wb_arbiter: RTL and testbench

- Writer side of the 32x32 register file.
- Merges two writeback sources into the single register-file write port:
  - the single-cycle ALU path, highest priority and never stalled;
  - the multi-cycle path (load/multiply results), buffered in a small FIFO.
- Produces registered regWrite/writeReg/writeData for the register file's negedge write.
- Publishes a pending-destination mask so the hazard unit can stall readers of registers that still have a buffered write.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/wb_fifo.sv | 101 ++++++++++
 rtl/reg_wb_arbiter.sv | 113 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register-index width, data width and the writeback request record.
package pipeline_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          dst;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Multi-cycle writeback buffer: ordered storage with per-entry live bits that younger ALU
// writes can clear, plus the pending-destination mask consumed by the hazard unit.
module wb_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DATA_W,
    parameter int AW    = REG_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [AW-1:0]              push_reg,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [AW-1:0]              kill_reg,
    output logic [AW-1:0]              head_reg,
    output logic [DW-1:0]              head_data,
    output logic                       head_live,
    output logic [$clog2(DEPTH):0]     count,
    output logic [(1<<AW)-1:0]         pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] live_q, live_d;

    logic [AW-1:0]    dst_mem  [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [NR-1:0]    entry_mask [DEPTH];

    // A same-edge enqueue counts as older than the ALU write, so it is killed too.
    logic push_live;
    assign push_live = (push_reg != '0) && !(kill_en && (push_reg == kill_reg));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic kill_hit;
            assign kill_hit = kill_en && (dst_mem[gi] == kill_reg);
            assign live_d[gi] = (push && (tail_q == PW'(gi))) ? push_live :
                                (pop  && (head_q == PW'(gi))) ? 1'b0 :
                                (live_q[gi] && !kill_hit);
            assign entry_mask[gi] = live_q[gi] ? (NR'(1) << dst_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | entry_mask[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
        end
    end

    // Payload storage needs no reset: live bits and count gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            dst_mem[tail_q]  <= push_reg;
            data_mem[tail_q] <= push_data;
        end
    end

    assign head_reg  = dst_mem[head_q];
    assign head_data = data_mem[head_q];
    assign head_live = live_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: ALU results win, buffered multi-cycle results drain otherwise.
// Optional macro WB_BYPASS_EN lets an mc result skip an empty FIFO straight into the output register.
module reg_wb_arbiter
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DATA_W,
    parameter int AW    = REG_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [AW-1:0]           alu_reg,
    input  logic [DW-1:0]           alu_data,
    input  logic                    mc_valid,
    output logic                    mc_ready,
    input  logic [AW-1:0]           mc_reg,
    input  logic [DW-1:0]           mc_data,
    output logic                    regWrite,
    output logic [AW-1:0]           writeReg,
    output logic [DW-1:0]           writeData,
    output logic [(1<<AW)-1:0]      pending,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          mc_fire;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          kill_en;
    logic [AW-1:0] head_reg;
    logic [DW-1:0] head_data;
    logic          head_live;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] writereg_q, writereg_d;
    logic [DW-1:0] writedata_q, writedata_d;

    // Ready looks only at occupancy, so a full FIFO refuses even when it pops this edge.
    assign mc_ready = rst && (fifo_count < CW'(DEPTH));
    assign mc_fire  = mc_valid && mc_ready;

`ifdef WB_BYPASS_EN
    assign bypass = mc_fire && !alu_valid && (fifo_count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push    = mc_fire && !bypass;
    assign pop     = !alu_valid && (fifo_count != '0);
    assign kill_en = alu_valid && (alu_reg != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (mc_reg),
        .push_data (mc_data),
        .pop       (pop),
        .kill_en   (kill_en),
        .kill_reg  (alu_reg),
        .head_reg  (head_reg),
        .head_data (head_data),
        .head_live (head_live),
        .count     (fifo_count),
        .pending   (pending)
    );

    always_comb begin
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        if (alu_valid) begin
            regwrite_d  = (alu_reg != '0);
            writereg_d  = alu_reg;
            writedata_d = alu_data;
        end else if (pop) begin
            // A killed head is discarded silently; index/data keep their last values.
            regwrite_d = head_live;
            if (head_live) begin
                writereg_d  = head_reg;
                writedata_d = head_data;
            end
        end else if (bypass) begin
            regwrite_d  = (mc_reg != '0);
            writereg_d  = mc_reg;
            writedata_d = mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    assign regWrite  = regwrite_q;
    assign writeReg  = writereg_q;
    assign writeData = writedata_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: priority, FIFO drain order, kill rule, register 0 and reset.
module tb_reg_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    alu_valid;
    logic [AW-1:0]           alu_reg;
    logic [DW-1:0]           alu_data;
    logic                    mc_valid;
    logic                    mc_ready;
    logic [AW-1:0]           mc_reg;
    logic [DW-1:0]           mc_data;
    logic                    regWrite;
    logic [AW-1:0]           writeReg;
    logic [DW-1:0]           writeData;
    logic [(1<<AW)-1:0]      pending;
    logic [$clog2(DEPTH):0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_reg     (mc_reg),
        .mc_data    (mc_data),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t alu=%0b/%0d mc=%0b/%0d rdy=%0b -> we=%0b reg=%0d data=%0h cnt=%0d pend=%08h",
                 $time, alu_valid, alu_reg, mc_valid, mc_reg, mc_ready,
                 regWrite, writeReg, writeData, fifo_count, pending);
    endtask

    initial begin
        rst = 1'b0; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
        #2;
        check_eq("rst_we",    regWrite, 0);
        check_eq("rst_reg",   writeReg, 0);
        check_eq("rst_data",  writeData, 0);
        check_eq("rst_pend",  pending, 0);
        check_eq("rst_cnt",   fifo_count, 0);
        check_eq("rst_ready", mc_ready, 0);
        #6 rst = 1'b1;

        // ALU single-cycle write
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h2A;
        step();
        check_eq("alu_we",   regWrite, 1);
        check_eq("alu_reg",  writeReg, 3);
        check_eq("alu_data", writeData, 32'h2A);
        alu_valid = 1'b0;
        step();
        check_eq("alu_we_off", regWrite, 0);
        check_eq("alu_hold",   writeReg, 3);

        // Single multi-cycle write
        check_eq("mc_ready_idle", mc_ready, 1);
        mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'h55;
        step();
        mc_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check_eq("byp_we",   regWrite, 1);
        check_eq("byp_reg",  writeReg, 7);
        check_eq("byp_data", writeData, 32'h55);
        check_eq("byp_pend", pending, 0);
        check_eq("byp_cnt",  fifo_count, 0);
        step();
        check_eq("byp_we_off", regWrite, 0);
`else
        check_eq("mc1_we",   regWrite, 0);
        check_eq("mc1_pend", pending, 64'd1 << 7);
        check_eq("mc1_cnt",  fifo_count, 1);
        step();
        check_eq("mc2_we",   regWrite, 1);
        check_eq("mc2_reg",  writeReg, 7);
        check_eq("mc2_data", writeData, 32'h55);
        check_eq("mc2_pend", pending, 0);
        check_eq("mc2_cnt",  fifo_count, 0);
`endif

        // Fill under sustained ALU traffic, fifth offer refused
        alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h77;
        for (int k = 0; k < 5; k++) begin
            mc_valid = 1'b1; mc_reg = AW'(8 + k); mc_data = 32'h100 + k;
            step();
        end
        check_eq("full_cnt",   fifo_count, 4);
        check_eq("full_ready", mc_ready, 0);
        check_eq("full_pend",  pending, 64'h0000_0F00);
        check_eq("full_alu",   writeReg, 20);
        mc_valid = 1'b0; alu_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("drain_we",   regWrite, 1);
            check_eq("drain_reg",  writeReg, 64'(8 + k));
            check_eq("drain_data", writeData, 64'(32'h100 + k));
        end
        check_eq("drain_cnt",   fifo_count, 0);
        check_eq("drain_ready", mc_ready, 1);
        step();
        check_eq("drain_idle", regWrite, 0);

        // Younger ALU write kills buffered entry
        alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h1;
        mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 32'h1;
        step();
        check_eq("kill_pend0", pending, 64'd1 << 9);
        check_eq("kill_cnt0",  fifo_count, 1);
        mc_valid = 1'b0; alu_reg = 5'd9; alu_data = 32'h2;
        step();
        check_eq("kill_we",    regWrite, 1);
        check_eq("kill_reg",   writeReg, 9);
        check_eq("kill_data",  writeData, 2);
        check_eq("kill_pend1", pending, 0);
        check_eq("kill_cnt1",  fifo_count, 1);
        alu_valid = 1'b0;
        step();
        check_eq("kill_pop_we",   regWrite, 0);
        check_eq("kill_pop_data", writeData, 2);
        check_eq("kill_pop_cnt",  fifo_count, 0);

        // Same-edge enqueue is older than the ALU write
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h3;
        mc_valid = 1'b1; mc_reg = 5'd5; mc_data = 32'h4;
        step();
        mc_valid = 1'b0; alu_valid = 1'b0;
        check_eq("same_pend", pending, 0);
        check_eq("same_cnt",  fifo_count, 1);
        check_eq("same_data", writeData, 3);
        step();
        check_eq("same_pop_we",   regWrite, 0);
        check_eq("same_pop_data", writeData, 3);
        check_eq("same_pop_cnt",  fifo_count, 0);

        // Register 0 from both sources
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hDEAD;
        mc_valid = 1'b1; mc_reg = 5'd0; mc_data = 32'hBEEF;
        step();
        mc_valid = 1'b0; alu_valid = 1'b0;
        check_eq("r0_we",   regWrite, 0);
        check_eq("r0_reg",  writeReg, 0);
        check_eq("r0_cnt",  fifo_count, 1);
        check_eq("r0_pend", pending, 0);
        step();
        check_eq("r0_pop_we",   regWrite, 0);
        check_eq("r0_pop_cnt",  fifo_count, 0);
        check_eq("r0_pop_data", writeData, 32'hDEAD);

        // Asynchronous reset with two buffered entries
        alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h99;
        mc_valid = 1'b1; mc_reg = 5'd12; mc_data = 32'hC;
        step();
        mc_reg = 5'd13; mc_data = 32'hD;
        step();
        mc_valid = 1'b0;
        check_eq("pre_rst_cnt",  fifo_count, 2);
        check_eq("pre_rst_pend", pending, (64'd1 << 12) | (64'd1 << 13));
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_we",    regWrite, 0);
        check_eq("mid_rst_reg",   writeReg, 0);
        check_eq("mid_rst_data",  writeData, 0);
        check_eq("mid_rst_pend",  pending, 0);
        check_eq("mid_rst_cnt",   fifo_count, 0);
        check_eq("mid_rst_ready", mc_ready, 0);
        #1 rst = 1'b1;
        alu_valid = 1'b0;
        step();
        check_eq("post_rst_we",    regWrite, 0);
        check_eq("post_rst_cnt",   fifo_count, 0);
        check_eq("post_rst_ready", mc_ready, 1);
        step();
        check_eq("post_rst_we2",   regWrite, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
